tap_line: RTL and testbench
===========================

TAP_LINE -- requirements
Module: tap_line

Interface
REQ-001 SHALL have parameter BITS_PER_ELEM, default 8, width of one sample and one tap element.
REQ-002 SHALL have parameter NUM_ELEM, default 7, number of tap elements in the window.
REQ-003 SHALL have parameter DECIMATE, default 1, number of accepted samples per output window once the line is full; legal range 1..255.
REQ-004 SHALL have port i_clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port i_rst_n  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port i_sample_valid  input  1  i_sample is accepted this cycle.
REQ-007 SHALL have port i_sample  input  BITS_PER_ELEM  incoming unsigned sample.
REQ-008 SHALL have port i_flush  input  1  synchronous clear of the window.
REQ-009 SHALL have port o_taps  output  NUM_ELEM*BITS_PER_ELEM  window; element k at bits [BITS_PER_ELEM*k +: BITS_PER_ELEM]; element 0 newest.
REQ-010 SHALL have port o_taps_valid  output  1  one-cycle pulse: o_taps holds a new window for the downstream FIR.
REQ-011 SHALL have port o_fill  output  $clog2(NUM_ELEM+1)  number of valid elements held, saturating at NUM_ELEM.
REQ-012 SHALL have port o_full  output  1  high when o_fill == NUM_ELEM.

Function
REQ-013 SHALL, on an accepted sample, shift the window: element k takes element k-1 for k = NUM_ELEM-1..1, element 0 takes i_sample, all in the same edge.
REQ-014 SHALL hold o_taps unchanged in cycles with i_sample_valid low.
REQ-015 SHALL implement two states: FILL (o_fill < NUM_ELEM) and RUN (o_fill == NUM_ELEM).
REQ-016 SHALL, in FILL, increment o_fill by 1 per accepted sample; transition FILL->RUN on the sample bringing o_fill to NUM_ELEM.
REQ-017 SHALL, in RUN, keep o_fill at NUM_ELEM (saturate) and keep shifting on accepted samples; RUN->FILL only on flush or reset.
REQ-018 SHALL maintain a decimation counter dec_cnt (0..DECIMATE-1), held at 0 in FILL.
REQ-019 SHALL, for each accepted sample after which the window is full (the completing sample included), assert o_taps_valid on the following cycle iff dec_cnt == 0 before that sample, then advance dec_cnt modulo DECIMATE.
REQ-020 SHALL register o_taps_valid: latency one edge after the accepting edge, coincident with the updated o_taps; deasserted in every other cycle.
REQ-021 SHALL, with DECIMATE = 1, pulse o_taps_valid for every accepted sample in RUN and for the completing sample.
REQ-022 SHALL, on i_flush high, clear all tap elements to 0, o_fill to 0, dec_cnt to 0, o_taps_valid to 0, and enter FILL.
REQ-023 SHALL give i_flush priority over i_sample_valid in the same cycle; that sample is discarded.
REQ-024 SHALL compute o_full combinationally from registered o_fill or as a register updated on the same edge; either way consistent with o_fill every cycle.
REQ-025 SHALL treat i_sample as opaque data; no arithmetic on sample values.

Reset
REQ-026 SHALL, with i_rst_n low at a rising edge, set o_taps = 0, o_taps_valid = 0, o_fill = 0, o_full = 0, dec_cnt = 0, state FILL.
REQ-027 SHALL give reset priority over i_flush and i_sample_valid; reset mid-fill or mid-RUN discards all held samples.

Verification
REQ-028 SHALL cover fill: defaults, samples 1..7 on 7 consecutive cycles -> o_fill counts 1..7, o_full and one o_taps_valid pulse one cycle after sample 7, o_taps elements 0..6 = 7,6,5,4,3,2,1.
REQ-029 SHALL cover streaming: full line, sample 8 -> o_taps_valid pulse, elements 0..6 = 8,7,6,5,4,3,2; o_fill stays 7.
REQ-030 SHALL cover gaps: valid toggled every other cycle during fill -> o_taps and o_fill change only on valid cycles; no o_taps_valid before the 7th sample.
REQ-031 SHALL cover decimation: DECIMATE = 3, 13 consecutive samples -> o_taps_valid after samples 7, 10, 13 only.
REQ-032 SHALL cover flush: i_flush and i_sample_valid both high in RUN with sample 0xAA -> next cycle o_taps = 0, o_fill = 0, o_taps_valid = 0, 0xAA absent; refill requires 7 new samples.
REQ-033 SHALL cover reset mid-operation: i_rst_n low for 1 cycle after 4 samples -> all outputs 0; next 7 samples produce exactly one o_taps_valid, after the 7th.

Source files
------------

// File: rtl/tap_line.sv
// Sliding tap window feeding a downstream FIR: newest sample at element 0,
// with fill tracking and decimated "new window" pulses once the line is full.
module tap_line #(
  parameter int BITS_PER_ELEM = 8,
  parameter int NUM_ELEM      = 7,
  parameter int DECIMATE      = 1
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_sample_valid,
  input  logic [BITS_PER_ELEM-1:0]          i_sample,
  input  logic                              i_flush,
  output logic [NUM_ELEM*BITS_PER_ELEM-1:0] o_taps,
  output logic                              o_taps_valid,
  output logic [$clog2(NUM_ELEM+1)-1:0]     o_fill,
  output logic                              o_full
);

  // state | meaning
  // FILL  | fewer than NUM_ELEM valid elements held, dec_cnt held at 0
  // RUN   | window full, pulses gated by the decimation counter
  localparam int FW = $clog2(NUM_ELEM+1);
  localparam logic [0:0] FILL = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]               state;
  logic [FW-1:0]            fill;
  logic [7:0]               dec_cnt;
  logic [7:0]               dec_next;
  logic                     taps_valid;
  logic [BITS_PER_ELEM-1:0] taps [NUM_ELEM];

  // DECIMATE is at most 255, so an 8-bit counter covers every legal setting.
  always_comb begin
    dec_next = dec_cnt + 8'd1;
    if (dec_cnt == 8'(DECIMATE-1))
      dec_next = 8'd0;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_flush) begin
      state      <= FILL;
      fill       <= '0;
      dec_cnt    <= 8'd0;
      taps_valid <= 1'b0;
      for (int k = 0; k < NUM_ELEM; k++)
        taps[k] <= '0;
    end else begin
      taps_valid <= 1'b0;
      if (i_sample_valid) begin
        taps[0] <= i_sample;
        for (int k = 1; k < NUM_ELEM; k++)
          taps[k] <= taps[k-1];
        if (state == FILL) begin
          // dec_cnt is 0 throughout FILL, so the completing sample always pulses.
          if (fill == FW'(NUM_ELEM-1)) begin
            state      <= RUN;
            fill       <= FW'(NUM_ELEM);
            taps_valid <= 1'b1;
            dec_cnt    <= dec_next;
          end else begin
            fill <= fill + FW'(1);
          end
        end else begin
          taps_valid <= (dec_cnt == 8'd0);
          dec_cnt    <= dec_next;
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_ELEM; k++) begin : g_taps
    assign o_taps[BITS_PER_ELEM*k +: BITS_PER_ELEM] = taps[k];
  end

  assign o_taps_valid = taps_valid;
  assign o_fill       = fill;
  assign o_full       = (fill == FW'(NUM_ELEM));

endmodule

// File: tb/tb_tap_line.sv
// Scoreboard bench for tap_line: stimulus pushes expected windows, monitors
// pop and compare on every o_taps_valid pulse. Two instances: DECIMATE 1 and 3.
module tb_tap_line;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n, a_valid, a_flush, a_tv, a_full;
  logic [7:0]  a_sample;
  logic [55:0] a_taps;
  logic [2:0]  a_fill;

  logic        b_rst_n, b_valid, b_flush, b_tv, b_full;
  logic [7:0]  b_sample;
  logic [55:0] b_taps;
  logic [2:0]  b_fill;

  int checks = 0;
  int errors = 0;
  logic [55:0] qa [$];
  logic [55:0] qb [$];

  tap_line #(.BITS_PER_ELEM(8), .NUM_ELEM(7), .DECIMATE(1)) dut_a (
    .i_clk(clk), .i_rst_n(a_rst_n), .i_sample_valid(a_valid), .i_sample(a_sample),
    .i_flush(a_flush), .o_taps(a_taps), .o_taps_valid(a_tv), .o_fill(a_fill), .o_full(a_full)
  );

  tap_line #(.BITS_PER_ELEM(8), .NUM_ELEM(7), .DECIMATE(3)) dut_b (
    .i_clk(clk), .i_rst_n(b_rst_n), .i_sample_valid(b_valid), .i_sample(b_sample),
    .i_flush(b_flush), .o_taps(b_taps), .o_taps_valid(b_tv), .o_fill(b_fill), .o_full(b_full)
  );

  // Window after `cnt` samples whose newest value is `top`: element k = top-k, zero beyond cnt.
  function automatic logic [55:0] win(input int top, input int cnt);
    logic [55:0] w;
    w = '0;
    for (int k = 0; k < 7; k++)
      if (k < cnt) w[8*k +: 8] = 8'(top - k);
    return w;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step_a(input logic v, input logic [7:0] s, input logic f, input logic r);
    a_valid = v; a_sample = s; a_flush = f; a_rst_n = r;
    @(posedge clk); #1;
    a_valid = 1'b0; a_flush = 1'b0; a_rst_n = 1'b1;
  endtask

  task automatic step_b(input logic v, input logic [7:0] s, input logic r);
    b_valid = v; b_sample = s; b_rst_n = r;
    @(posedge clk); #1;
    b_valid = 1'b0; b_rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (a_tv) begin
      checks++;
      if (qa.size() == 0) begin
        errors++;
        $display("FAIL a_unexpected_valid actual=1 required=0 taps=%h", a_taps);
      end else begin
        logic [55:0] e;
        e = qa.pop_front();
        if (a_taps !== e) begin
          errors++;
          $display("FAIL a_window actual=%h required=%h", a_taps, e);
        end
      end
    end
    if (b_tv) begin
      checks++;
      if (qb.size() == 0) begin
        errors++;
        $display("FAIL b_unexpected_valid actual=1 required=0 taps=%h", b_taps);
      end else begin
        logic [55:0] e;
        e = qb.pop_front();
        if (b_taps !== e) begin
          errors++;
          $display("FAIL b_window actual=%h required=%h", b_taps, e);
        end
      end
    end
  end

  initial begin
    a_rst_n = 1'b0; a_valid = 1'b0; a_sample = 8'h00; a_flush = 1'b0;
    b_rst_n = 1'b0; b_valid = 1'b0; b_sample = 8'h00; b_flush = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    a_rst_n = 1'b1; b_rst_n = 1'b1;

    chk("reset_taps", 64'(a_taps), 64'd0);
    chk("reset_fill", 64'(a_fill), 64'd0);
    chk("reset_full", 64'(a_full), 64'd0);
    chk("reset_valid", 64'(a_tv), 64'd0);

    // fill with 1..7
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) qa.push_back(win(7, 7));
      step_a(1'b1, 8'(i), 1'b0, 1'b1);
      chk($sformatf("fill_cnt_%0d", i), 64'(a_fill), 64'(i));
      chk($sformatf("fill_full_%0d", i), 64'(a_full), 64'(i == 7));
    end
    chk("fill_taps", 64'(a_taps), 64'(win(7, 7)));

    // streaming
    qa.push_back(win(8, 7));
    step_a(1'b1, 8'd8, 1'b0, 1'b1);
    chk("stream_taps", 64'(a_taps), 64'(win(8, 7)));
    chk("stream_fill", 64'(a_fill), 64'd7);
    step_a(1'b0, 8'h55, 1'b0, 1'b1);
    chk("idle_valid", 64'(a_tv), 64'd0);
    chk("idle_taps_hold", 64'(a_taps), 64'(win(8, 7)));

    // flush wins over a coincident sample
    step_a(1'b1, 8'hAA, 1'b1, 1'b1);
    chk("flush_taps", 64'(a_taps), 64'd0);
    chk("flush_fill", 64'(a_fill), 64'd0);
    chk("flush_full", 64'(a_full), 64'd0);
    chk("flush_valid", 64'(a_tv), 64'd0);

    // gapped fill
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) qa.push_back(win(8'h17, 7));
      step_a(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
      chk($sformatf("gap_fill_%0d", i), 64'(a_fill), 64'(i));
      chk($sformatf("gap_taps_%0d", i), 64'(a_taps), 64'(win(8'h10 + i, i)));
      step_a(1'b0, 8'hEE, 1'b0, 1'b1);
      chk($sformatf("gap_hold_fill_%0d", i), 64'(a_fill), 64'(i));
      chk($sformatf("gap_hold_taps_%0d", i), 64'(a_taps), 64'(win(8'h10 + i, i)));
    end

    // reset mid-fill
    step_a(1'b0, 8'h00, 1'b1, 1'b1);
    for (int i = 1; i <= 4; i++)
      step_a(1'b1, 8'(8'h30 + i), 1'b0, 1'b1);
    chk("pre_reset_fill", 64'(a_fill), 64'd4);
    step_a(1'b1, 8'hCC, 1'b1, 1'b0);
    chk("rst_taps", 64'(a_taps), 64'd0);
    chk("rst_fill", 64'(a_fill), 64'd0);
    chk("rst_full", 64'(a_full), 64'd0);
    chk("rst_valid", 64'(a_tv), 64'd0);
    for (int i = 1; i <= 7; i++) begin
      if (i == 7) qa.push_back(win(8'h27, 7));
      step_a(1'b1, 8'(8'h20 + i), 1'b0, 1'b1);
      chk($sformatf("refill_cnt_%0d", i), 64'(a_fill), 64'(i));
    end
    chk("refill_taps", 64'(a_taps), 64'(win(8'h27, 7)));

    // decimation by 3: pulses after samples 7, 10, 13
    for (int i = 1; i <= 13; i++) begin
      if (i == 7 || i == 10 || i == 13) qb.push_back(win(i, 7));
      step_b(1'b1, 8'(i), 1'b1);
    end
    chk("dec_taps", 64'(b_taps), 64'(win(13, 7)));
    chk("dec_fill", 64'(b_fill), 64'd7);
    step_b(1'b0, 8'h00, 1'b1);
    step_b(1'b0, 8'h00, 1'b1);

    chk("a_queue_drained", 64'(qa.size()), 64'd0);
    chk("b_queue_drained", 64'(qb.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
